// File: rtl/ram_prog_loader.sv
// Purpose: DEPTH x DATA_W synchronous RAM with registered run-mode read and a valid/ready program loader.
// Latency: run-mode read data valid 1 clk after address/CE_bar are sampled; a loader write lands at the accepting edge.
// Backpressure: prog_ready is low outside LOAD and while prog_start is high; prog_valid low simply stalls the load.
module ram_prog_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run_or_prog,
  input  logic [ADDR_W-1:0] address,
  input  logic              CE_bar,
  output logic [DATA_W-1:0] memory_value,
  output logic              mem_valid,
  input  logic              prog_start,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_valid,
  output logic              prog_ready,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [ADDR_W:0]   prog_count,
  output logic              prog_done
);

  localparam int DEPTH = 2 ** ADDR_W;
  // Count value held just before the final beat of a full load.
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_reg;

  // Strobes from the FSM: restart clears the pointer/count, beat accepts a word.
  logic restart;
  logic beat;

  // State register; reset and run mode both return the loader to IDLE.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state, handshake and strobe decode; prog_start always beats a coincident word.
  always_comb begin
    state_nx   = state;
    prog_ready = 1'b0;
    restart    = 1'b0;
    beat       = 1'b0;
    if (run_or_prog) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (prog_start) begin
            state_nx = LOAD;
            restart  = 1'b1;
          end
        end
        LOAD: begin
          prog_ready = !prog_start;
          if (prog_start) begin
            restart = 1'b1;
          end else if (prog_valid) begin
            beat = 1'b1;
            if (prog_count == LAST_CNT) begin
              state_nx = DONE;
            end
          end
        end
        DONE: begin
          if (prog_start) begin
            state_nx = LOAD;
            restart  = 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  // Load pointer, word count and completion flag; these hold across run mode.
  always_ff @(posedge clk) begin
    if (clr) begin
      prog_addr  <= '0;
      prog_count <= '0;
      prog_done  <= 1'b0;
    end else if (restart) begin
      prog_addr  <= '0;
      prog_count <= '0;
      prog_done  <= 1'b0;
    end else if (beat) begin
      prog_addr  <= prog_addr + 1'b1;
      prog_count <= prog_count + 1'b1;
      if (prog_count == LAST_CNT) begin
        prog_done <= 1'b1;
      end
    end
  end

  // RAM write port; contents survive clr, but clr still blocks a same-edge write.
  always_ff @(posedge clk) begin
    if (!clr && beat) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Registered run-mode read; mem_valid drops whenever the RAM is not selected.
  always_ff @(posedge clk) begin
    if (clr) begin
      rd_reg    <= '0;
      mem_valid <= 1'b0;
    end else if (run_or_prog && !CE_bar) begin
      rd_reg    <= mem[address];
      mem_valid <= 1'b1;
    end else begin
      mem_valid <= 1'b0;
    end
  end

  // Drive zero when idle so the shared bus can be OR-combined.
  assign memory_value = mem_valid ? rd_reg : '0;

endmodule

// File: tb/tb_ram_prog_loader.sv
// Directed bench for ram_prog_loader: per-cycle vector table plus hand-built abort/reset sequences.
// Each vector is driven on the falling edge and its outputs are checked 1 time unit after the rising edge.
// prog_ready is checked with the vector's inputs still applied.
module tb_ram_prog_loader;

  logic       clk = 1'b0;
  logic       clr;
  logic       run_or_prog;
  logic [3:0] address;
  logic       CE_bar;
  logic [7:0] memory_value;
  logic       mem_valid;
  logic       prog_start;
  logic [7:0] prog_data;
  logic       prog_valid;
  logic       prog_ready;
  logic [3:0] prog_addr;
  logic [4:0] prog_count;
  logic       prog_done;

  always #5 clk = ~clk;

  ram_prog_loader #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk          (clk),
    .clr          (clr),
    .run_or_prog  (run_or_prog),
    .address      (address),
    .CE_bar       (CE_bar),
    .memory_value (memory_value),
    .mem_valid    (mem_valid),
    .prog_start   (prog_start),
    .prog_data    (prog_data),
    .prog_valid   (prog_valid),
    .prog_ready   (prog_ready),
    .prog_addr    (prog_addr),
    .prog_count   (prog_count),
    .prog_done    (prog_done)
  );

  typedef struct {
    logic       clr;
    logic       rop;
    logic [3:0] addr;
    logic       ce_bar;
    logic       start;
    logic [7:0] data;
    logic       valid;
    logic [7:0] e_val;
    logic       e_mv;
    logic       e_rdy;
    logic [3:0] e_addr;
    logic [4:0] e_cnt;
    logic       e_done;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   row    = 0;

  function automatic vec_t mk(int c, int r, int a, int ce, int st, int d, int vl,
                              int ev, int emv, int erdy, int ea, int ec, int ed);
    vec_t v;
    v.clr    = 1'(c);
    v.rop    = 1'(r);
    v.addr   = 4'(a);
    v.ce_bar = 1'(ce);
    v.start  = 1'(st);
    v.data   = 8'(d);
    v.valid  = 1'(vl);
    v.e_val  = 8'(ev);
    v.e_mv   = 1'(emv);
    v.e_rdy  = 1'(erdy);
    v.e_addr = 4'(ea);
    v.e_cnt  = 5'(ec);
    v.e_done = 1'(ed);
    return v;
  endfunction

  // Program-mode cycle: bus outputs are always expected quiet.
  function automatic vec_t pv(int st, int d, int vl, int erdy, int ea, int ec, int ed);
    return mk(0, 0, 0, 1, st, d, vl, 0, 0, erdy, ea, ec, ed);
  endfunction

  // Run-mode read cycle with CE_bar low.
  function automatic vec_t rv(int a, int ev, int ea, int ec, int ed);
    return mk(0, 1, a, 0, 0, 0, 0, ev, 1, 0, ea, ec, ed);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (vector %0d): got 0x%0h, expected 0x%0h", nm, row, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    clr         = v.clr;
    run_or_prog = v.rop;
    address     = v.addr;
    CE_bar      = v.ce_bar;
    prog_start  = v.start;
    prog_data   = v.data;
    prog_valid  = v.valid;
    @(posedge clk);
    #1;
    chk("memory_value", int'(memory_value), int'(v.e_val));
    chk("mem_valid",    int'(mem_valid),    int'(v.e_mv));
    chk("prog_ready",   int'(prog_ready),   int'(v.e_rdy));
    chk("prog_addr",    int'(prog_addr),    int'(v.e_addr));
    chk("prog_count",   int'(prog_count),   int'(v.e_cnt));
    chk("prog_done",    int'(prog_done),    int'(v.e_done));
    row++;
  endtask

  initial begin
    clr = 1'b1; run_or_prog = 1'b0; address = '0; CE_bar = 1'b1;
    prog_start = 1'b0; prog_data = '0; prog_valid = 1'b0;

    // Reset, then start a load: ready is masked while prog_start is held.
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(pv(1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(pv(0, 0, 0, 1, 0, 0, 0));
    // Full load with prog_valid held high, data (k-3) mod 16.
    for (int k = 0; k < 16; k++)
      tbl.push_back(pv(0, (k - 3) & 15, 1, (k < 15) ? 1 : 0, (k + 1) & 15, k + 1, (k == 15) ? 1 : 0));
    // A word offered in DONE must be ignored (would land on word 0).
    tbl.push_back(pv(0, 8'hBB, 1, 0, 0, 16, 1));
    for (int a = 0; a < 16; a++)
      tbl.push_back(rv(a, (a - 3) & 15, 0, 16, 1));
    // Deselect, then reselect.
    tbl.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 16, 1));
    tbl.push_back(rv(5, 2, 0, 16, 1));
    // Reload with prog_valid toggling; idle cycles carry junk data.
    tbl.push_back(pv(1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 16; k++) begin
      tbl.push_back(pv(0, (k - 3) & 15, 1, (k < 15) ? 1 : 0, (k + 1) & 15, k + 1, (k == 15) ? 1 : 0));
      tbl.push_back(pv(0, 8'hAA, 0, (k < 15) ? 1 : 0, (k + 1) & 15, k + 1, (k == 15) ? 1 : 0));
    end
    for (int a = 0; a < 16; a++)
      tbl.push_back(rv(a, (a - 3) & 15, 0, 16, 1));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i]);

    // Abort by prog_start after 5 beats; the colliding word 0xEE must not land at word 5.
    apply(pv(1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++)
      apply(pv(0, 8'h40 + k, 1, 1, k + 1, k + 1, 0));
    apply(pv(1, 8'hEE, 1, 0, 0, 0, 0));
    // Reload 5 words, then abort by switching to run mode.
    for (int k = 0; k < 5; k++)
      apply(pv(0, 8'h50 + k, 1, 1, k + 1, k + 1, 0));
    for (int a = 0; a < 6; a++)
      apply(rv(a, (a < 5) ? (8'h50 + a) : 2, 5, 5, 0));
    // Back in prog mode without prog_start: loader sits in IDLE and ignores the word.
    apply(pv(0, 8'hCC, 1, 0, 5, 5, 0));
    apply(rv(5, 2, 5, 5, 0));

    // clr after 7 beats: counters clear, words 0..6 retained, word 7 untouched.
    apply(pv(1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 7; k++)
      apply(pv(0, 8'h60 + k, 1, 1, k + 1, k + 1, 0));
    apply(mk(1, 0, 0, 1, 0, 8'hFF, 1, 0, 0, 0, 0, 0, 0));
    for (int a = 0; a < 8; a++)
      apply(rv(a, (a < 7) ? (8'h60 + a) : 4, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
